vga_sync_gen: RTL

//   VGA 640x480@60 timing generator feeding the brick/paddle/ball renderers and the top-level

---
 rtl/vga_sync_gen.sv | 138 +++++++++++++
 1 files changed

// File: rtl/vga_sync_gen.sv
// ---------------------------------------------------------------------------
// vga_sync_gen
//   VGA raster timing generator (640x480@60 by default). The board clock is
//   divided down to a one-clock pixel strobe; horizontal and vertical
//   counters step on that strobe and drive sync, blanking, pixel coordinates
//   and a once-per-frame strobe for the game logic.
//
// Ports
//   clock      in   board clock, all state changes on the rising edge
//   reset      in   asynchronous, active-low reset
//   hSync      out  horizontal sync, equal to SYNC_POL during the sync interval
//   vSync      out  vertical sync, equal to SYNC_POL during the sync interval
//   videoON    out  high while pixelX/pixelY lie inside the visible area
//   pTick      out  one-clock pixel-advance strobe, once per TICK_DIV clocks
//   pixelX     out  horizontal count, 0..H_TOTAL-1
//   pixelY     out  vertical count, 0..V_TOTAL-1
//   frameTick  out  one-clock strobe on the last pixel of each frame
//
// Every output is a register loaded from the next-state counter values, so
// sync, blanking and frameTick carry no skew relative to pixelX/pixelY.
// ---------------------------------------------------------------------------
module vga_sync_gen #(
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int TICK_DIV  = 4,
    parameter bit SYNC_POL  = 1'b0
) (
    input  logic       clock,
    input  logic       reset,
    output logic       hSync,
    output logic       vSync,
    output logic       videoON,
    output logic       pTick,
    output logic [9:0] pixelX,
    output logic [9:0] pixelY,
    output logic       frameTick
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    // Divider width; a divide-by-one still needs a one-bit counter that
    // simply stays at zero.
    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VISIBLE  = 10'(H_DISPLAY);
    localparam logic [9:0] V_VISIBLE  = 10'(V_DISPLAY);
    localparam logic [9:0] HS_FIRST   = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_LAST    = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST   = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_LAST    = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic [TICK_W-1:0] tick_cnt;
    logic [TICK_W-1:0] tick_cnt_nxt;
    logic              ptick_nxt;
    logic [9:0]        x_nxt;
    logic [9:0]        y_nxt;
    logic              hsync_nxt;
    logic              vsync_nxt;
    logic              video_nxt;
    logic              frame_nxt;

    // Next-state: divider, raster counters and decode of the new position
    always_comb begin
        tick_cnt_nxt = tick_cnt + TICK_W'(1);
        if (tick_cnt >= TICK_LAST) begin
            tick_cnt_nxt = '0;
        end

        // pTick marks the cycle in which the divider sits at its last count.
        ptick_nxt = (tick_cnt_nxt == TICK_LAST);

        // Counters step only on the edge that closes a pTick cycle. The >=
        // comparisons keep the counters bounded even from a corrupted state.
        x_nxt = pixelX;
        y_nxt = pixelY;
        if (pTick) begin
            if (pixelX >= H_LAST) begin
                x_nxt = '0;
                if (pixelY >= V_LAST) begin
                    y_nxt = '0;
                end else begin
                    y_nxt = pixelY + 10'd1;
                end
            end else begin
                x_nxt = pixelX + 10'd1;
            end
        end

        hsync_nxt = ~SYNC_POL;
        if ((x_nxt >= HS_FIRST) && (x_nxt <= HS_LAST)) begin
            hsync_nxt = SYNC_POL;
        end

        vsync_nxt = ~SYNC_POL;
        if ((y_nxt >= VS_FIRST) && (y_nxt <= VS_LAST)) begin
            vsync_nxt = SYNC_POL;
        end

        video_nxt = (x_nxt < H_VISIBLE) && (y_nxt < V_VISIBLE);

        // Asserted together with the pTick that will close the last pixel.
        frame_nxt = ptick_nxt && (x_nxt == H_LAST) && (y_nxt == V_LAST);
    end

    // Registered state and outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tick_cnt  <= '0;
            pTick     <= 1'b0;
            pixelX    <= '0;
            pixelY    <= '0;
            hSync     <= ~SYNC_POL;
            vSync     <= ~SYNC_POL;
            videoON   <= 1'b0;
            frameTick <= 1'b0;
        end else begin
            tick_cnt  <= tick_cnt_nxt;
            pTick     <= ptick_nxt;
            pixelX    <= x_nxt;
            pixelY    <= y_nxt;
            hSync     <= hsync_nxt;
            vSync     <= vsync_nxt;
            videoON   <= video_nxt;
            frameTick <= frame_nxt;
        end
    end

endmodule
